// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters enabled with `define MC_PERF_CNT_EN.
module multi_cycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Opcode,
    input  logic        mem_ready,
    output logic        PC_w,
    output logic        PC_w_cond,
    output logic        IR_w,
    output logic        Reg_w,
    output logic        Mem_w,
    output logic        Mem_r,
    output logic        I_or_D,
    output logic        Reg_dst,
    output logic        Mem_to_reg,
    output logic        ALU_src_A,
    output logic        Ext_zero,
    output logic [1:0]  ALU_src_B,
    output logic [1:0]  ALU_op,
    output logic [1:0]  PC_src,
    output logic        illegal_op,
    output logic [3:0]  state_o,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] MEM_ADDR  = 4'd3;
    localparam logic [3:0] MEM_READ  = 4'd4;
    localparam logic [3:0] MEM_WB    = 4'd5;
    localparam logic [3:0] MEM_WRITE = 4'd6;
    localparam logic [3:0] EXEC_R    = 4'd7;
    localparam logic [3:0] R_WB      = 4'd8;
    localparam logic [3:0] EXEC_I    = 4'd9;
    localparam logic [3:0] I_WB      = 4'd10;
    localparam logic [3:0] BRANCH    = 4'd11;
    localparam logic [3:0] JUMP      = 4'd12;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state;
    logic [3:0] state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign state_o = state;

    always_comb begin
        state_nxt  = state;
        PC_w       = 1'b0;
        PC_w_cond  = 1'b0;
        IR_w       = 1'b0;
        Reg_w      = 1'b0;
        Mem_w      = 1'b0;
        Mem_r      = 1'b0;
        I_or_D     = 1'b0;
        Reg_dst    = 1'b0;
        Mem_to_reg = 1'b0;
        ALU_src_A  = 1'b0;
        Ext_zero   = 1'b0;
        ALU_src_B  = 2'b00;
        ALU_op     = 2'b00;
        PC_src     = 2'b00;
        illegal_op = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                Mem_r     = 1'b1;
                ALU_src_B = 2'b01;
                ALU_op    = 2'b01;
                IR_w      = mem_ready;
                PC_w      = mem_ready;
                state_nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALU_src_B = 2'b11;
                ALU_op    = 2'b01;
                unique case (1'b1)
                    (Opcode == OP_R):
                        state_nxt = EXEC_R;
                    (Opcode == OP_ADDIU),
                    (Opcode == OP_ORI):
                        state_nxt = EXEC_I;
                    (Opcode == OP_LW),
                    (Opcode == OP_SW):
                        state_nxt = MEM_ADDR;
                    (Opcode == OP_BEQ):
                        state_nxt = BRANCH;
                    (Opcode == OP_J):
                        state_nxt = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_nxt  = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                ALU_op    = 2'b01;
                state_nxt = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                Mem_r     = 1'b1;
                I_or_D    = 1'b1;
                state_nxt = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                Reg_w      = 1'b1;
                Mem_to_reg = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WRITE: begin
                Mem_w     = 1'b1;
                I_or_D    = 1'b1;
                state_nxt = mem_ready ? FETCH : MEM_WRITE;
            end
            EXEC_R: begin
                ALU_src_A = 1'b1;
                ALU_op    = 2'b10;
                state_nxt = R_WB;
            end
            R_WB: begin
                Reg_w     = 1'b1;
                Reg_dst   = 1'b1;
                state_nxt = FETCH;
            end
            EXEC_I: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                Ext_zero  = (Opcode == OP_ORI);
                ALU_op    = (Opcode == OP_ORI) ? 2'b11 : 2'b01;
                state_nxt = I_WB;
            end
            I_WB: begin
                // IR is stable here, so re-deriving from Opcode holds EXEC_I's value
                Reg_w     = 1'b1;
                Ext_zero  = (Opcode == OP_ORI);
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALU_src_A = 1'b1;
                PC_w_cond = 1'b1;
                PC_src    = 2'b01;
                state_nxt = FETCH;
            end
            JUMP: begin
                PC_w      = 1'b1;
                PC_src    = 2'b10;
                state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] ins_q;
    logic        retire;

    assign retire = (state_nxt == FETCH) &&
                    ((state == MEM_WB) || (state == MEM_WRITE) ||
                     (state == R_WB)   || (state == I_WB) ||
                     (state == BRANCH) || (state == JUMP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= 32'd0;
            ins_q <= 32'd0;
        end else begin
            if (state != IDLE) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (retire) begin
                ins_q <= ins_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cyc_q;
    assign instr_cnt = ins_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed table-driven bench for multi_cycle_control.
module tb_multi_cycle_control;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    // {PC_w,PC_w_cond,IR_w,Reg_w,Mem_w,Mem_r,I_or_D,Reg_dst,Mem_to_reg,
    //  ALU_src_A,Ext_zero,ALU_src_B,ALU_op,PC_src,illegal_op}
    localparam logic [17:0] W_ZERO = 18'd0;
    localparam logic [17:0] W_FNR = 18'b0_0_0_0_0_1_0_0_0_0_0_01_01_00_0;
    localparam logic [17:0] W_FRD = 18'b1_0_1_0_0_1_0_0_0_0_0_01_01_00_0;
    localparam logic [17:0] W_DEC = 18'b0_0_0_0_0_0_0_0_0_0_0_11_01_00_0;
    localparam logic [17:0] W_ILL = 18'b0_0_0_0_0_0_0_0_0_0_0_11_01_00_1;
    localparam logic [17:0] W_MA  = 18'b0_0_0_0_0_0_0_0_0_1_0_10_01_00_0;
    localparam logic [17:0] W_MR  = 18'b0_0_0_0_0_1_1_0_0_0_0_00_00_00_0;
    localparam logic [17:0] W_MWB = 18'b0_0_0_1_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [17:0] W_MW  = 18'b0_0_0_0_1_0_1_0_0_0_0_00_00_00_0;
    localparam logic [17:0] W_ER  = 18'b0_0_0_0_0_0_0_0_0_1_0_00_10_00_0;
    localparam logic [17:0] W_RWB = 18'b0_0_0_1_0_0_0_1_0_0_0_00_00_00_0;
    localparam logic [17:0] W_EIA = 18'b0_0_0_0_0_0_0_0_0_1_0_10_01_00_0;
    localparam logic [17:0] W_EIO = 18'b0_0_0_0_0_0_0_0_0_1_1_10_11_00_0;
    localparam logic [17:0] W_IWA = 18'b0_0_0_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] W_IWO = 18'b0_0_0_1_0_0_0_0_0_0_1_00_00_00_0;
    localparam logic [17:0] W_BR  = 18'b0_1_0_0_0_0_0_0_0_1_0_00_00_01_0;
    localparam logic [17:0] W_J   = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] w;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  Opcode;
    logic        mem_ready;
    logic        PC_w, PC_w_cond, IR_w, Reg_w, Mem_w, Mem_r;
    logic        I_or_D, Reg_dst, Mem_to_reg, ALU_src_A, Ext_zero;
    logic [1:0]  ALU_src_B, ALU_op, PC_src;
    logic        illegal_op;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instr_cnt;
    logic [17:0] act_w;

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;
    int exp_ins = 0;
    vec_t tbl[$];

    multi_cycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .mem_ready  (mem_ready),
        .PC_w       (PC_w),
        .PC_w_cond  (PC_w_cond),
        .IR_w       (IR_w),
        .Reg_w      (Reg_w),
        .Mem_w      (Mem_w),
        .Mem_r      (Mem_r),
        .I_or_D     (I_or_D),
        .Reg_dst    (Reg_dst),
        .Mem_to_reg (Mem_to_reg),
        .ALU_src_A  (ALU_src_A),
        .Ext_zero   (Ext_zero),
        .ALU_src_B  (ALU_src_B),
        .ALU_op     (ALU_op),
        .PC_src     (PC_src),
        .illegal_op (illegal_op),
        .state_o    (state_o),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    assign act_w = {PC_w, PC_w_cond, IR_w, Reg_w, Mem_w, Mem_r, I_or_D,
                    Reg_dst, Mem_to_reg, ALU_src_A, Ext_zero, ALU_src_B,
                    ALU_op, PC_src, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef MC_PERF_CNT_EN
        chk({tag, " cycle_cnt"}, cycle_cnt, exp_cyc);
        chk({tag, " instr_cnt"}, instr_cnt, exp_ins);
`else
        chk({tag, " cycle_cnt"}, cycle_cnt, 32'd0);
        chk({tag, " instr_cnt"}, instr_cnt, 32'd0);
`endif
    endtask

    function automatic vec_t v(input logic [5:0] op, input logic mr,
                               input logic [3:0] st, input logic [17:0] w);
        vec_t r;
        r.op = op;
        r.mr = mr;
        r.st = st;
        r.w  = w;
        return r;
    endfunction

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        Opcode    = x.op;
        mem_ready = x.mr;
        #1;
        chk($sformatf("v%0d state", idx), {28'd0, state_o}, {28'd0, x.st});
        chk($sformatf("v%0d ctrl", idx), {14'd0, act_w}, {14'd0, x.w});
        chk_cnt($sformatf("v%0d", idx));
        if (x.st != 4'd0) exp_cyc++;
        if ((x.st == 4'd5) || (x.st == 4'd8) || (x.st == 4'd10) ||
            (x.st == 4'd11) || (x.st == 4'd12) ||
            ((x.st == 4'd6) && x.mr)) exp_ins++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        Opcode    = OP_R;
        mem_ready = 1'b0;
        exp_cyc   = 0;
        exp_ins   = 0;
        @(negedge clk);
        #1;
        chk("rst state", {28'd0, state_o}, 32'd0);
        chk("rst ctrl", {14'd0, act_w}, {14'd0, W_ZERO});
        chk_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst idle", {28'd0, state_o}, 32'd0);
        chk("post-rst ctrl", {14'd0, act_w}, {14'd0, W_ZERO});
    endtask

    task automatic push_fetch_dec(input logic [5:0] op);
        tbl.push_back(v(op, 1'b1, 4'd1, W_FRD));
        tbl.push_back(v(op, 1'b0, 4'd2, W_DEC));
    endtask

    initial begin
        rst_n     = 1'b0;
        Opcode    = OP_R;
        mem_ready = 1'b0;

        // lw with two wait cycles in FETCH and in MEM_READ
        tbl.push_back(v(OP_LW, 1'b0, 4'd1, W_FNR));
        tbl.push_back(v(OP_LW, 1'b0, 4'd1, W_FNR));
        tbl.push_back(v(OP_LW, 1'b1, 4'd1, W_FRD));
        tbl.push_back(v(OP_LW, 1'b0, 4'd2, W_DEC));
        tbl.push_back(v(OP_LW, 1'b1, 4'd3, W_MA));
        tbl.push_back(v(OP_LW, 1'b0, 4'd4, W_MR));
        tbl.push_back(v(OP_LW, 1'b0, 4'd4, W_MR));
        tbl.push_back(v(OP_LW, 1'b1, 4'd4, W_MR));
        tbl.push_back(v(OP_LW, 1'b0, 4'd5, W_MWB));
        // R-type, mem_ready toggled where it must be ignored
        push_fetch_dec(OP_R);
        tbl.push_back(v(OP_R, 1'b1, 4'd7, W_ER));
        tbl.push_back(v(OP_R, 1'b0, 4'd8, W_RWB));
        // sw with no wait, then sw with one wait
        push_fetch_dec(OP_SW);
        tbl.push_back(v(OP_SW, 1'b1, 4'd3, W_MA));
        tbl.push_back(v(OP_SW, 1'b1, 4'd6, W_MW));
        push_fetch_dec(OP_SW);
        tbl.push_back(v(OP_SW, 1'b0, 4'd3, W_MA));
        tbl.push_back(v(OP_SW, 1'b0, 4'd6, W_MW));
        tbl.push_back(v(OP_SW, 1'b1, 4'd6, W_MW));
        // beq, j, illegal
        push_fetch_dec(OP_BEQ);
        tbl.push_back(v(OP_BEQ, 1'b1, 4'd11, W_BR));
        push_fetch_dec(OP_J);
        tbl.push_back(v(OP_J, 1'b0, 4'd12, W_J));
        tbl.push_back(v(OP_BAD, 1'b1, 4'd1, W_FRD));
        tbl.push_back(v(OP_BAD, 1'b0, 4'd2, W_ILL));
        // addiu and ori
        push_fetch_dec(OP_ADDIU);
        tbl.push_back(v(OP_ADDIU, 1'b0, 4'd9, W_EIA));
        tbl.push_back(v(OP_ADDIU, 1'b0, 4'd10, W_IWA));
        push_fetch_dec(OP_ORI);
        tbl.push_back(v(OP_ORI, 1'b0, 4'd9, W_EIO));
        tbl.push_back(v(OP_ORI, 1'b0, 4'd10, W_IWO));
        tbl.push_back(v(OP_R, 1'b0, 4'd1, W_FNR));

        do_reset();
        foreach (tbl[i]) apply(tbl[i], i);

        // counter scenario: addiu, ori, lw, then reset in the middle of ori
        do_reset();
        apply(v(OP_ADDIU, 1'b1, 4'd1, W_FRD), 100);
        apply(v(OP_ADDIU, 1'b0, 4'd2, W_DEC), 101);
        apply(v(OP_ADDIU, 1'b0, 4'd9, W_EIA), 102);
        apply(v(OP_ADDIU, 1'b0, 4'd10, W_IWA), 103);
        apply(v(OP_ORI, 1'b1, 4'd1, W_FRD), 104);
        apply(v(OP_ORI, 1'b0, 4'd2, W_DEC), 105);
        apply(v(OP_ORI, 1'b0, 4'd9, W_EIO), 106);
        apply(v(OP_ORI, 1'b0, 4'd10, W_IWO), 107);
        apply(v(OP_LW, 1'b1, 4'd1, W_FRD), 108);
        apply(v(OP_LW, 1'b0, 4'd2, W_DEC), 109);
        apply(v(OP_LW, 1'b0, 4'd3, W_MA), 110);
        apply(v(OP_LW, 1'b1, 4'd4, W_MR), 111);
        apply(v(OP_LW, 1'b0, 4'd5, W_MWB), 112);
        apply(v(OP_ORI, 1'b0, 4'd1, W_FNR), 113);
`ifdef MC_PERF_CNT_EN
        chk("three instr_cnt", instr_cnt, 32'd3);
        chk("three cycle_cnt", cycle_cnt, 32'd13);
`endif
        apply(v(OP_ORI, 1'b1, 4'd1, W_FRD), 114);
        apply(v(OP_ORI, 1'b0, 4'd2, W_DEC), 115);
        apply(v(OP_ORI, 1'b0, 4'd9, W_EIO), 116);
        apply(v(OP_ORI, 1'b0, 4'd10, W_IWO), 117);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-ori rst state", {28'd0, state_o}, 32'd0);
        chk("mid-ori rst Reg_w", {31'd0, Reg_w}, 32'd0);
        chk("mid-ori rst ctrl", {14'd0, act_w}, {14'd0, W_ZERO});
        chk("mid-ori rst cycle_cnt", cycle_cnt, 32'd0);
        chk("mid-ori rst instr_cnt", instr_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("restart fetch", {28'd0, state_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle MIPS control FSM: sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps, one instruction at a time. Supports R-type, addiu, ori, lw, sw, beq and j. Sits beside the multi-cycle datapath: reads `Opcode` from the instruction register and drives every mux select and write enable. Waits on a single memory-ready handshake for instruction fetch, data read and data write.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Opcode`  in  6  IR[31:26]; stable from DECODE until the next FETCH, because IR is written only in FETCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PC_w`, `PC_w_cond`, `IR_w`, `Reg_w`, `Mem_w`, `Mem_r`  out  1 each  write and read enables.
- `I_or_D`, `Reg_dst`, `Mem_to_reg`, `ALU_src_A`, `Ext_zero`  out  1 each  selects; `Ext_zero=1` zero-extends the immediate.
- `ALU_src_B`  out  2  00 = B register, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- `ALU_op`  out  2  00 = sub, 01 = add, 10 = decode by funct, 11 = or.
- `PC_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `state_o`  out  4  current state, for debug.
- `cycle_cnt`, `instr_cnt`  out  32 each  performance counters (see Configuration).

## Operation
- State encoding, used on `state_o`:
  - IDLE = 0, FETCH = 1, DECODE = 2
  - MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6
  - EXEC_R = 7, R_WB = 8, EXEC_I = 9, I_WB = 10
  - BRANCH = 11, JUMP = 12
- Outputs are 0 unless listed for a state.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: `Mem_r=1`, `I_or_D=0`, `ALU_src_A=0`, `ALU_src_B=01`, `ALU_op=01`, `PC_src=00`.
  - `IR_w` and `PC_w` equal `mem_ready` (Mealy).
  - Stays in FETCH while `mem_ready=0`; moves to DECODE when it is 1.
- DECODE: `ALU_src_A=0`, `ALU_src_B=11`, `ALU_op=01` (computes the branch target). Next state by opcode:
  - 000000 (R-type) → EXEC_R
  - 001001 (addiu) or 001101 (ori) → EXEC_I
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - any other opcode: `illegal_op=1` this cycle, next state FETCH, no writes.
- MEM_ADDR: `ALU_src_A=1`, `ALU_src_B=10`, `ALU_op=01`. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `Mem_r=1`, `I_or_D=1`. Holds until `mem_ready=1`, then MEM_WB.
- MEM_WB: `Reg_w=1`, `Reg_dst=0`, `Mem_to_reg=1`. Next state FETCH.
- MEM_WRITE: `Mem_w=1`, `I_or_D=1`. Held until `mem_ready=1`, then FETCH.
- EXEC_R: `ALU_src_A=1`, `ALU_src_B=00`, `ALU_op=10`. Next state R_WB.
- R_WB: `Reg_w=1`, `Reg_dst=1`, `Mem_to_reg=0`. Next state FETCH.
- EXEC_I: `ALU_src_A=1`, `ALU_src_B=10`. Next state I_WB.
  - addiu: `ALU_op=01`, `Ext_zero=0`.
  - ori: `ALU_op=11`, `Ext_zero=1`.
- I_WB: `Reg_w=1`, `Reg_dst=0`, `Mem_to_reg=0`. Holds `Ext_zero` from EXEC_I. Next state FETCH.
- BRANCH: `ALU_src_A=1`, `ALU_src_B=00`, `ALU_op=00`, `PC_w_cond=1`, `PC_src=01`. Next state FETCH.
- JUMP: `PC_w=1`, `PC_src=10`. Next state FETCH.

## Timing
- Reset: `rst_n` low forces state to IDLE immediately. All outputs read 0, including both counters.
- Reset asserted mid-instruction aborts the instruction; no write enable stays asserted after the reset edge.
- Cycle counts with `mem_ready` high in every access cycle, including FETCH:
  - R-type, addiu, ori: 4
  - lw: 5
  - sw: 4
  - beq, j: 3
  - illegal: 2
- Each cycle `mem_ready` is low in a waiting state adds one cycle.
- `mem_ready` is ignored in all states except FETCH, MEM_READ and MEM_WRITE.
- `Mem_w` stays high for the whole MEM_WRITE wait. Memory commits the write only in the cycle `mem_ready=1`.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle while not in IDLE.
  - `instr_cnt` increments on each transition to FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH or JUMP. Illegal opcodes are not counted.
  - Both counters wrap modulo 2^32 and are cleared by reset.
- Macro undefined: both ports are present and tied to 0; no counter flops exist.

## Test plan
- Hold reset, release: all outputs 0 and `state_o=0` during reset; `state_o=1` one cycle after release.
- lw with `mem_ready` held low 2 cycles in both FETCH and MEM_READ: sequence 1,1,1,2,3,4,4,4,5,1; `Reg_w=1` only in state 5; 9 cycles total.
- R-type then sw with `mem_ready=1`: R-type takes 4 cycles, `Reg_dst=1` in R_WB; sw takes 4 cycles, `Mem_w=1` for exactly 1 cycle.
- beq then j: `PC_w_cond=1` with `PC_src=01` in BRANCH; `PC_w=1` with `PC_src=10` in JUMP; 3 cycles each.
- Opcode 6'b111111: `illegal_op` high for 1 cycle in DECODE, no write enables, return to FETCH; `instr_cnt` unchanged.
- `MC_PERF_CNT_EN` defined, three instructions (addiu, ori, lw): `instr_cnt=3`; `cycle_cnt` matches the elapsed cycles, including the IDLE exclusion. Assert reset mid-ori: both counters read 0.
